// File: rtl/memc_arbiter.sv
// memc_arbiter: two-requester front end for the single memc port.
//
// Requester A (CPU core) and requester B (loader/debug) share one memc
// access path. One transaction is in flight at a time: the winner's
// address/data are latched and one rd or wr strobe is issued. A read then
// waits RD_LATENCY cycles and captures memc_rd_data. Either way the winner
// gets a one-cycle ack. Nothing is granted while memc_busy is high.
//
// Build option: define MEMC_ARB_RR_EN for round-robin arbitration between
// simultaneous requests. Without it, A always beats B.
//
// Ports:
//   arb_clk, arb_reset               clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wr_data      requester A transaction inputs
//   a_gnt/a_ack/a_rd_data            requester A ownership, completion, read data
//   b_*                              the same set for requester B
//   memc_busy                        memc not ready (reset/BIST/error)
//   memc_rd_enable/memc_wr_enable    one-cycle memc strobes
//   memc_addr/memc_wr_data           latched transaction address/data
//   memc_rd_data                     memc read data
module memc_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 2
) (
  input  logic                  arb_clk,
  input  logic                  arb_reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  output logic                  a_gnt,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rd_data,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  output logic                  b_gnt,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rd_data,
  input  logic                  memc_busy,
  output logic                  memc_rd_enable,
  output logic                  memc_wr_enable,
  output logic [ADDR_WIDTH-1:0] memc_addr,
  output logic [DATA_WIDTH-1:0] memc_wr_data,
  input  logic [DATA_WIDTH-1:0] memc_rd_data
);

  // The wait counter is 4 bits wide, so only 1..15 can be represented.
  if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
    $error("memc_arbiter: RD_LATENCY must be in the range 1..15");
  end

  localparam logic [3:0] LAT = 4'(RD_LATENCY);

  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_IDLE  = 5'b00010,
    S_ISSUE = 5'b00100,
    S_WAIT  = 5'b01000,
    S_ACK   = 5'b10000
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  win_b_q, win_b_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                  a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DATA_WIDTH-1:0] a_rd_q, a_rd_d, b_rd_q, b_rd_d;
  logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;

  // Winner selection and the winner's transaction fields.
  logic                  pick_b;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef MEMC_ARB_RR_EN
  // last_b_q = 1 means B won the most recent grant; it resets to B so the
  // first contention goes to A.
  logic last_b_q, last_b_d;
  assign pick_b = b_req && (!a_req || !last_b_q);
`else
  assign pick_b = b_req && !a_req;
`endif

  assign sel_we    = pick_b ? b_we      : a_we;
  assign sel_addr  = pick_b ? b_addr    : a_addr;
  assign sel_wdata = pick_b ? b_wr_data : a_wr_data;

  always_ff @(posedge arb_clk) begin
    if (arb_reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      win_b_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      a_rd_q  <= '0;
      b_rd_q  <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
`ifdef MEMC_ARB_RR_EN
      last_b_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      win_b_q <= win_b_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      a_gnt_q <= a_gnt_d;
      b_gnt_q <= b_gnt_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      a_rd_q  <= a_rd_d;
      b_rd_q  <= b_rd_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
`ifdef MEMC_ARB_RR_EN
      last_b_q <= last_b_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    win_b_d = win_b_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    a_gnt_d = a_gnt_q;
    b_gnt_d = b_gnt_q;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    a_rd_d  = a_rd_q;
    b_rd_d  = b_rd_q;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
`ifdef MEMC_ARB_RR_EN
    last_b_d = last_b_q;
`endif

    if (state_q != S_INIT && memc_busy) begin
      // memc dropped out: abandon whatever is in flight without an ack.
      // Requesters still holding req are re-arbitrated once memc is back.
      state_d = S_INIT;
      cnt_d   = '0;
      a_gnt_d = 1'b0;
      b_gnt_d = 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (!memc_busy) state_d = S_IDLE;
        end
        S_IDLE: begin
          if (a_req || b_req) begin
            win_b_d = pick_b;
            we_d    = sel_we;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            a_gnt_d = !pick_b;
            b_gnt_d = pick_b;
            // Strobes are registered, so they are raised here to be
            // visible during the ISSUE cycle.
            rd_en_d = !sel_we;
            wr_en_d = sel_we;
            state_d = S_ISSUE;
`ifdef MEMC_ARB_RR_EN
            last_b_d = pick_b;
`endif
          end
        end
        S_ISSUE: begin
          if (we_q) begin
            a_ack_d = !win_b_q;
            b_ack_d = win_b_q;
            state_d = S_ACK;
          end else begin
            cnt_d   = LAT;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_d = cnt_q - 4'd1;
          // Counter moving 1 -> 0 marks the edge where read data is valid.
          if (cnt_q == 4'd1) begin
            if (win_b_q) b_rd_d = memc_rd_data;
            else         a_rd_d = memc_rd_data;
            a_ack_d = !win_b_q;
            b_ack_d = win_b_q;
            state_d = S_ACK;
          end
        end
        S_ACK: begin
          a_gnt_d = 1'b0;
          b_gnt_d = 1'b0;
          state_d = S_IDLE;
        end
        default: begin
          a_gnt_d = 1'b0;
          b_gnt_d = 1'b0;
          state_d = S_INIT;
        end
      endcase
    end
  end

  assign a_gnt          = a_gnt_q;
  assign a_ack          = a_ack_q;
  assign a_rd_data      = a_rd_q;
  assign b_gnt          = b_gnt_q;
  assign b_ack          = b_ack_q;
  assign b_rd_data      = b_rd_q;
  assign memc_rd_enable = rd_en_q;
  assign memc_wr_enable = wr_en_q;
  assign memc_addr      = addr_q;
  assign memc_wr_data   = wdata_q;

endmodule

// File: tb/tb_memc_arbiter.sv
// Testbench for memc_arbiter: a memc memory model answers the strobes, a
// driver issues directed and random transactions, and a monitor checks each
// grant/ack against an expected-transaction queue filled by the driver.
module tb_memc_arbiter;
  localparam int DW     = 8;
  localparam int AW     = 12;
  localparam int RD_LAT = 2;
`ifdef MEMC_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          arb_clk = 1'b0;
  logic          arb_reset, memc_busy;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr, memc_addr;
  logic [DW-1:0] a_wr_data, b_wr_data, a_rd_data, b_rd_data;
  logic          a_gnt, a_ack, b_gnt, b_ack;
  logic          memc_rd_enable, memc_wr_enable;
  logic [DW-1:0] memc_wr_data, memc_rd_data;

  memc_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RD_LAT)) dut (
    .arb_clk(arb_clk), .arb_reset(arb_reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wr_data(a_wr_data),
    .a_gnt(a_gnt), .a_ack(a_ack), .a_rd_data(a_rd_data),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wr_data(b_wr_data),
    .b_gnt(b_gnt), .b_ack(b_ack), .b_rd_data(b_rd_data),
    .memc_busy(memc_busy), .memc_rd_enable(memc_rd_enable),
    .memc_wr_enable(memc_wr_enable), .memc_addr(memc_addr),
    .memc_wr_data(memc_wr_data), .memc_rd_data(memc_rd_data)
  );

  always #5 arb_clk = ~arb_clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]};
  endfunction

  // ---------------- memc model ----------------
  logic [DW-1:0] mem [0:4095];
  int            cyc = 0;
  int            due = -100;
  logic [DW-1:0] due_data = '0;
  logic [DW-1:0] noise = '0;
  logic          rst_e = 1'b0, busy_e = 1'b0;

  always @(posedge arb_clk) begin
    cyc   <= cyc + 1;
    noise <= DW'($urandom);
    if (cyc == 0) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(AW'(i));
    end else if (memc_wr_enable) begin
      mem[memc_addr] <= memc_wr_data;
    end
    // Strobe seen at this edge was high in cycle cyc; data is valid
    // RD_LAT cycles after that.
    if (memc_rd_enable) begin
      due      <= cyc + RD_LAT;
      due_data <= mem[memc_addr];
    end
    rst_e  <= arb_reset;
    busy_e <= memc_busy;
  end

  assign memc_rd_data = (cyc == due) ? due_data : noise;

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic          is_b;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [0:4095];
  bit            model_last_b = 1'b1;

  task automatic push_exp(input bit is_b, input bit we, input logic [AW-1:0] ad,
                          input logic [DW-1:0] wd);
    exp_t e;
    e.is_b  = is_b;
    e.we    = we;
    e.addr  = ad;
    e.wdata = wd;
    e.rdata = we ? '0 : ref_mem[ad];
    if (we) ref_mem[ad] = wd;
    model_last_b = is_b;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic          a_gnt_p = 1'b0, b_gnt_p = 1'b0;
  int            a_gcyc = 0, b_gcyc = 0, en_cnt = 0, en_cyc = 0;
  logic          en_we = 1'b0;
  logic [AW-1:0] en_addr = '0;
  logic [DW-1:0] en_wd = '0;
  logic [DW-1:0] a_hold = '0, b_hold = '0;

  task automatic check_ack(input bit is_b);
    exp_t          e;
    int            gc;
    logic [DW-1:0] rd;
    chk("ack_queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      gc = is_b ? b_gcyc : a_gcyc;
      rd = is_b ? b_rd_data : a_rd_data;
      chk("ack_owner", 64'(is_b), 64'(e.is_b));
      chk("ack_gnt_high", 64'(is_b ? b_gnt : a_gnt), 64'd1);
      chk("ack_latency", 64'(cyc - gc), e.we ? 64'd1 : 64'(1 + RD_LAT));
      chk("enable_count", 64'(en_cnt), 64'd1);
      chk("enable_cycle", 64'(en_cyc), 64'(gc));
      chk("enable_type", 64'(en_we), 64'(e.we));
      chk("memc_addr", 64'(en_addr), 64'(e.addr));
      if (e.we) begin
        chk("memc_wr_data", 64'(en_wd), 64'(e.wdata));
        chk("rd_hold_on_write", 64'(rd), 64'(is_b ? b_hold : a_hold));
      end else begin
        chk("rd_data", 64'(rd), 64'(e.rdata));
        if (is_b) b_hold = rd;
        else      a_hold = rd;
      end
      $display("txn %s %s addr=0x%03h data=0x%02h cycle=%0d",
               is_b ? "B" : "A", e.we ? "WR" : "RD", e.addr,
               e.we ? e.wdata : rd, cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge arb_clk);
      if (rst_e) begin
        chk("reset_outputs", 64'({a_gnt, a_ack, a_rd_data, b_gnt, b_ack, b_rd_data,
                                  memc_rd_enable, memc_wr_enable}), 64'd0);
        chk("reset_memc_bus", 64'({memc_addr, memc_wr_data}), 64'd0);
        a_hold = '0;
        b_hold = '0;
      end else if (busy_e) begin
        chk("busy_quiet", 64'({a_gnt, b_gnt, a_ack, b_ack, memc_rd_enable,
                               memc_wr_enable}), 64'd0);
      end
      chk("single_gnt", 64'(a_gnt && b_gnt), 64'd0);
      if (a_gnt && !a_gnt_p) begin
        a_gcyc = cyc;
        en_cnt = 0;
        chk("gnt_queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("grant_owner_a", 64'(exp_q[0].is_b), 64'd0);
      end
      if (b_gnt && !b_gnt_p) begin
        b_gcyc = cyc;
        en_cnt = 0;
        chk("gnt_queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("grant_owner_b", 64'(exp_q[0].is_b), 64'd1);
      end
      a_gnt_p = a_gnt;
      b_gnt_p = b_gnt;
      if (memc_rd_enable || memc_wr_enable) begin
        en_cnt++;
        en_cyc  = cyc;
        en_we   = memc_wr_enable;
        en_addr = memc_addr;
        en_wd   = memc_wr_data;
        chk("one_enable", 64'(memc_rd_enable && memc_wr_enable), 64'd0);
      end
      if (a_ack) check_ack(1'b0);
      if (b_ack) check_ack(1'b1);
      if (!a_ack && !rst_e) chk("a_rd_hold", 64'(a_rd_data), 64'(a_hold));
      if (!b_ack && !rst_e) chk("b_rd_hold", 64'(b_rd_data), 64'(b_hold));
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ack(input bit is_b, input int limit);
    int n = 0;
    do begin
      @(posedge arb_clk); #1;
      n++;
    end while (!(is_b ? b_ack : a_ack) && n < limit);
    chk("ack_within_bound", 64'(is_b ? b_ack : a_ack), 64'd1);
  endtask

  // A requester with n>0 keeps req high for n transactions, then drops it
  // in the cycle after its last ack.
  task automatic run_txns(input int a_n, input bit awe, input logic [AW-1:0] aad,
                          input logic [DW-1:0] awd,
                          input int b_n, input bit bwe, input logic [AW-1:0] bad_,
                          input logic [DW-1:0] bwd);
    int ra = a_n, rb = b_n, ca = 0, cb = 0, guard = 0;
    bit pb;
    while (ra > 0 || rb > 0) begin
      if (ra > 0 && rb > 0) pb = RR ? !model_last_b : 1'b0;
      else                  pb = (rb > 0);
      if (pb) begin push_exp(1'b1, bwe, bad_, bwd); rb--; end
      else    begin push_exp(1'b0, awe, aad, awd);  ra--; end
    end
    @(posedge arb_clk); #1;
    a_we = awe; a_addr = aad; a_wr_data = awd; a_req = (a_n > 0);
    b_we = bwe; b_addr = bad_; b_wr_data = bwd; b_req = (b_n > 0);
    while ((ca < a_n || cb < b_n) && guard < 400) begin
      @(posedge arb_clk); #1;
      guard++;
      if (ca == a_n) a_req = 1'b0;
      if (cb == b_n) b_req = 1'b0;
      if (a_ack) ca++;
      if (b_ack) cb++;
    end
    chk("all_acks_within_bound", 64'(ca == a_n && cb == b_n), 64'd1);
    if (!(ca == a_n && cb == b_n)) exp_q.delete();
    @(posedge arb_clk); #1;
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  initial begin
    arb_reset = 1'b1; memc_busy = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wr_data = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wr_data = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(AW'(i));
    repeat (3) @(posedge arb_clk);
    #1 arb_reset = 1'b0;

    // Held off by BIST with a pending write from A.
    push_exp(1'b0, 1'b1, 12'h123, 8'h55);
    a_req = 1; a_we = 1; a_addr = 12'h123; a_wr_data = 8'h55;
    repeat (20) begin
      @(posedge arb_clk); #1;
      chk("init_no_gnt", 64'({a_gnt, memc_wr_enable}), 64'd0);
    end
    memc_busy = 1'b0;
    @(posedge arb_clk); #1;
    chk("gnt_low_entering_idle", 64'(a_gnt), 64'd0);
    @(posedge arb_clk); #1;
    chk("gnt_one_after_idle", 64'(a_gnt), 64'd1);
    wait_ack(1'b0, 20);
    @(posedge arb_clk); #1;
    a_req = 0;

    // Read back the value just written.
    run_txns(1, 1'b0, 12'h123, 8'h00, 0, 1'b0, 12'h000, 8'h00);

    // Both requesters held: four grants observed in arbitration order.
    if (RR) run_txns(2, 1'b1, 12'h010, 8'h3C, 2, 1'b1, 12'h020, 8'hC3);
    else    run_txns(4, 1'b1, 12'h010, 8'h3C, 1, 1'b1, 12'h020, 8'hC3);

    // Address range ends.
    run_txns(0, 1'b0, 12'h000, 8'h00, 1, 1'b0, 12'hFFF, 8'h00);
    run_txns(1, 1'b1, 12'h000, 8'hAA, 0, 1'b0, 12'h000, 8'h00);
    run_txns(0, 1'b0, 12'h000, 8'h00, 1, 1'b0, 12'h000, 8'h00);

    // memc_busy pulse during WAIT of an A read: dropped, then re-served.
    push_exp(1'b0, 1'b0, 12'h0FF, 8'h00);
    @(posedge arb_clk); #1;
    a_req = 1; a_we = 0; a_addr = 12'h0FF;
    for (int n = 0; n < 20 && !memc_rd_enable; n++) begin
      @(posedge arb_clk); #1;
    end
    chk("busy_test_rd_strobe", 64'(memc_rd_enable), 64'd1);
    @(posedge arb_clk); #1;
    memc_busy = 1'b1;
    repeat (3) begin
      @(posedge arb_clk); #1;
      chk("busy_abort_gnt_low", 64'({a_gnt, a_ack}), 64'd0);
    end
    memc_busy = 1'b0;
    wait_ack(1'b0, 30);
    @(posedge arb_clk); #1;
    a_req = 0;

    // Reset during ISSUE.
    push_exp(1'b0, 1'b0, 12'h456, 8'h00);
    @(posedge arb_clk); #1;
    a_req = 1; a_we = 0; a_addr = 12'h456;
    for (int n = 0; n < 20 && !a_gnt; n++) begin
      @(posedge arb_clk); #1;
    end
    chk("rst_test_in_issue", 64'({a_gnt, memc_rd_enable}), 64'd3);
    @(negedge arb_clk); #1;
    arb_reset = 1'b1;
    a_req = 0;
    exp_q.delete();
    model_last_b = 1'b1;
    @(posedge arb_clk); #1;
    arb_reset = 1'b0;
    chk("rst_in_issue_outputs", 64'({a_gnt, a_ack, a_rd_data, memc_rd_enable,
                                     memc_wr_enable}), 64'd0);
    repeat (3) @(posedge arb_clk);

    // Random traffic.
    for (int r = 0; r < 60; r++) begin
      int mode = $urandom_range(0, 2);
      logic [AW-1:0] ad[2];
      for (int k = 0; k < 2; k++) begin
        int s = $urandom_range(0, 7);
        ad[k] = (s == 0) ? 12'h000 : (s == 1) ? 12'hFFF : AW'($urandom);
      end
      run_txns((mode != 1) ? 1 : 0, 1'($urandom), ad[0], DW'($urandom),
               (mode != 0) ? 1 : 0, 1'($urandom), ad[1], DW'($urandom));
    end

    repeat (5) @(posedge arb_clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memc_arbiter.md
Name: memc_arbiter

Overview:
- Two-port arbiter in front of memc. Shares the single memc port between requester A (CPU core) and requester B (loader/debug port).
- Accepts one transaction at a time, drives memc's rd/wr enables for exactly one cycle, waits the read latency, then returns data and an ack to the winning requester.
- Holds off all requesters until memc finishes its power-on BIST (memc_busy low).

Parameters:
- DATA_WIDTH, 8, data bus width; must match memc.
- ADDR_WIDTH, 12, address width; must match memc.
- RD_LATENCY, 2, cycles from the memc_rd_enable cycle until memc_rd_data is valid; legal range 1..15.

Ports:
- arb_clk  in  1  clock, same domain as memc_clk.
- arb_reset  in  1  reset; synchronous, active-high.
- a_req  in  1  requester A transaction request.
- a_we  in  1  A: 1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  A address.
- a_wr_data  in  DATA_WIDTH  A write data.
- a_gnt  out  1  A owns memc (ISSUE through ACK).
- a_ack  out  1  A transaction complete, 1-cycle pulse.
- a_rd_data  out  DATA_WIDTH  A read data, valid when a_ack=1.
- b_req, b_we, b_addr, b_wr_data, b_gnt, b_ack, b_rd_data: identical set for requester B.
- memc_busy  in  1  memc not ready (reset/BIST/error).
- memc_rd_enable  out  1  memc read strobe.
- memc_wr_enable  out  1  memc write strobe.
- memc_addr  out  ADDR_WIDTH  latched transaction address.
- memc_wr_data  out  DATA_WIDTH  latched write data.
- memc_rd_data  in  DATA_WIDTH  memc read data.

Behaviour:
- All outputs are registered. While arb_reset=1 at a rising edge:
  - every output goes to 0;
  - state goes to INIT;
  - latency counter goes to 0;
  - last_winner goes to B.
- States are one-hot: INIT, IDLE, ISSUE, WAIT, ACK.
- INIT:
  - Hold while memc_busy=1.
  - When memc_busy=0, go to IDLE.
  - No gnt or ack is issued in INIT.
- IDLE:
  - Sample a_req and b_req. If neither is high, stay.
  - Otherwise pick a winner and latch its we, addr and wr_data into internal registers and onto memc_addr and memc_wr_data.
  - Set the winner's gnt and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - memc_rd_enable = !we, memc_wr_enable = we.
  - Read: load the counter with RD_LATENCY and go to WAIT.
  - Write: go to ACK.
- WAIT:
  - Both enables are 0 and the counter decrements each cycle.
  - On the edge where the counter reaches 0, capture memc_rd_data into the winner's rd_data register and go to ACK.
- ACK (1 cycle):
  - The winner's ack = 1; gnt is still high.
  - Next state is IDLE, with gnt cleared.
  - Non-winner rd_data holds its previous value.
- Latency, with the request sampled in IDLE at edge k:
  - Write: ISSUE in cycle k+1, ack high in cycle k+2.
  - Read: ack high in cycle k+2+RD_LATENCY.
  - A back-to-back request sampled in IDLE is served every 3 cycles (write) or 3+RD_LATENCY cycles (read).
- Requester rules:
  - Hold req, we, addr and wr_data stable from assertion through the ack cycle.
  - Deassert req in the cycle after ack unless starting a new transaction.
  - A req that is still high in IDLE is treated as a new transaction.
- Arbitration (default): fixed priority, A beats B on simultaneous requests.
- memc_busy rising in IDLE, ISSUE, WAIT or ACK:
  - Next state is INIT; both enables and all gnt/ack are cleared.
  - The in-flight transaction is dropped with no ack.
  - A requester still holding req is re-arbitrated after INIT exits.
- arb_reset mid-transaction: same as memc_busy, plus last_winner is reset.
- Counter width is 4 bits. RD_LATENCY=0 is illegal; the implementation carries a synthesis-off check that fires at elaboration if RD_LATENCY is 0 or greater than 15.

Optional Feature:
- Macro: MEMC_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On simultaneous requests, grant the requester that is not last_winner.
  - last_winner updates on every IDLE->ISSUE transition.
  - The first contention after reset goes to A.
  - A single requester is always granted, regardless of last_winner.
- Undefined: fixed A-over-B priority; no last_winner register is built.

Test Plan:
- Hold memc_busy=1 for 20 cycles after reset with a_req=1 -> no gnt or enable while busy; a_gnt rises one cycle after IDLE is reached.
- A writes 0x55 to 0x123, then reads 0x123 with the memc model returning 0x55 at RD_LATENCY=2:
  - memc_wr_enable is high for exactly 1 cycle;
  - the write ack arrives at k+2;
  - the read ack arrives at k+4 with a_rd_data=0x55;
  - B outputs stay unchanged throughout.
- a_req and b_req both held high for 4 transactions:
  - default build: A wins all four;
  - with MEMC_ARB_RR_EN: grants go A, B, A, B.
- B reads 0xFFF, then A writes 0xAA to 0x000 -> addresses at both ends of the range pass unchanged, and b_rd_data holds its value through A's ack.
- memc_busy pulses high during WAIT of an A read -> no a_ack; state returns to INIT; a_req still high is re-served after memc_busy falls and a_ack follows.
- arb_reset asserted during ISSUE -> all outputs are 0 on the next cycle, with no stray enable or ack.
